muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per clock, with pipeline flush and busy/done handshake.
module muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [1:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic [DATA_WIDTH-1:0]   r_quot;
  logic [DATA_WIDTH-1:0]   r_rem;
  logic [DATA_WIDTH-1:0]   r_result;

  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_div_idx;
  logic [DATA_WIDTH:0]     w_madd;
  logic [2*DATA_WIDTH-1:0] w_prod_next;
  logic [DATA_WIDTH:0]     w_rem_sh;
  logic [DATA_WIDTH:0]     w_diff;
  logic                    w_q_bit;
  logic [DATA_WIDTH-1:0]   w_rem_next;
  logic [DATA_WIDTH-1:0]   w_quot_next;
  logic                    w_last;
  logic [DATA_WIDTH-1:0]   w_final;

  // Multiplier bits are consumed LSB first; dividend bits MSB first.
  assign w_idx     = r_count[IDX_W-1:0];
  assign w_div_idx = IDX_W'(DATA_WIDTH - 1) - w_idx;

  assign w_madd      = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]}
                     + (r_b[w_idx] ? {1'b0, r_a} : '0);
  assign w_prod_next = (2*DATA_WIDTH)'({w_madd, r_prod[DATA_WIDTH-1:0]} >> 1);

  // Bit DATA_WIDTH of the difference is the borrow: set means "restore".
  assign w_rem_sh    = {r_rem, r_a[w_div_idx]};
  assign w_diff      = w_rem_sh - {1'b0, r_b};
  assign w_q_bit     = ~w_diff[DATA_WIDTH];
  assign w_rem_next  = w_q_bit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
  assign w_quot_next = {r_quot[DATA_WIDTH-2:0], w_q_bit};

  assign w_last = (r_count == CNT_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
    w_final = w_rem_next;
    case (r_op)
      OP_MUL:   w_final = w_prod_next[DATA_WIDTH-1:0];
      OP_MULHU: w_final = w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIVU:  w_final = w_quot_next;
      default:  w_final = w_rem_next;
    endcase
  end

  // NOTE: all state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_a     <= src_a;
            r_b     <= src_b;
            r_prod  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_prod  <= w_prod_next;
            r_quot  <= w_quot_next;
            r_rem   <= w_rem_next;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_result <= w_final;
              r_state  <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed results,
// latency, flush, reset-abort and operand-isolation checks.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Accept an operation, then scramble inputs and toggle start while it runs.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int edges;
    int busy_cyc;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk); #1;
    op       = ~o;
    src_b    = ~b;
    edges    = 0;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      start = ~start;
      src_a = $urandom;
      @(posedge clk); #1;
      edges++;
    end
    if (busy) busy_cyc++;
    check({tag, "_latency"}, edges, 32);
    check({tag, "_busy_cycles"}, busy_cyc, 33);
    check({tag, "_result"}, result, exp);
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_after"}, {31'b0, done}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_hold"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic accept_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;

    run_op("mul_7x6",      2'b00, 32'd7,          32'd6,          32'd42);
    run_op("mulhu_ffxff",  2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run_op("mul_ffxff",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
    run_op("mulhu_2^31x4", 2'b01, 32'h8000_0000,  32'd4,          32'd2);
    run_op("divu_100_7",   2'b10, 32'd100,        32'd7,          32'd14);
    run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2);
    run_op("divu_5_0",     2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF);
    run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5);

    // start together with flush in IDLE is ignored
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_start_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    check("idle_flush_start_hold", {31'b0, busy}, 32'd0);

    // flush on the 10th BUSY edge
    accept_op(2'b00, 32'h1234, 32'd5);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_hold", result, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_late_done", {31'b0, done}, 32'd0);
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9);

    // reset on the 20th BUSY edge
    accept_op(2'b10, 32'd100, 32'd7);
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", {31'b0, done}, 32'd0);

    run_op("divu_ffffffff_16", 2'b10, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    run_op("remu_ffffffff_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
